// File: rtl/bootrom_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bootrom_gen_pkg
// Description : Shared types and constants for the parametrised boot ROM:
//               reset boot image, default checksum and scan FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package bootrom_gen_pkg;

  // Number of words in the read-only boot image.
  localparam int IMAGE_WORDS = 7;

  // Reset contents of the image region; all higher words reset to zero.
  localparam logic [15:0] BOOT_IMAGE [IMAGE_WORDS] = '{
    16'hF200, 16'h4000, 16'hF800, 16'h1007, 16'hF400, 16'h3008, 16'h4000
  };

  // Mod-2**16 sum of the reset contents.
  localparam logic [15:0] EXP_CSUM_DEFAULT = 16'h9E0F;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    DONE = 2'd1,
    IDLE = 2'd2
  } scan_state_e;

  // Reset value of word idx: image word inside the image, zero beyond it.
  function automatic logic [15:0] image_word(input int unsigned idx);
    logic [15:0] word;
    word = 16'h0000;
    if (idx < IMAGE_WORDS) word = BOOT_IMAGE[idx[2:0]];
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bootrom_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : bootrom_gen_if
// Description : CPU-side bus of the boot ROM (access, lock, rescan, status).
// Revision    : 1.0 - initial release
// ============================================================================
interface bootrom_gen_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          cs;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          lock;
  logic          rescan;
  logic          ready;
  logic [DW-1:0] dout;
  logic          rvalid;
  logic          err;
  logic          boot_ok;
  logic [DW-1:0] csum;

  modport master (
    output cs, we, addr, din, lock, rescan,
    input  ready, dout, rvalid, err, boot_ok, csum
  );

  modport slave (
    input  cs, we, addr, din, lock, rescan,
    output ready, dout, rvalid, err, boot_ok, csum
  );
endinterface
`default_nettype wire

// File: rtl/bootrom_gen_scan.sv
`default_nettype none
// ============================================================================
// Module      : bootrom_gen_scan
// Description : Self-check scanner: walks every word, sums it mod 2**DW and
//               publishes the sum and a match flag; gates CPU access.
// Revision    : 1.0 - initial release
// ============================================================================
module bootrom_gen_scan
  import bootrom_gen_pkg::*;
#(
  parameter int            DW       = 16,
  parameter int            AW       = 4,
  parameter int            DEPTH    = 16,
  parameter logic [DW-1:0] EXP_CSUM = DW'(EXP_CSUM_DEFAULT)
) (
  input  wire           romclk,
  input  wire           rst,
  input  wire           rescan,
  input  wire  [DW-1:0] word,
  output logic [AW-1:0] scan_idx,
  output logic          ready,
  output logic [DW-1:0] csum,
  output logic          boot_ok
);

  scan_state_e   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] csum_q, csum_d;
  logic          boot_ok_q, boot_ok_d;

  // Next-state logic: accumulate during SCAN, publish in DONE, wait in IDLE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    csum_d    = csum_q;
    boot_ok_d = boot_ok_q;
    case (state_q)
      SCAN: begin
        acc_d = acc_q + word;
        if (idx_q == AW'(DEPTH - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      DONE: begin
        csum_d    = acc_q;
        boot_ok_d = (acc_q == EXP_CSUM);
        state_d   = IDLE;
      end
      IDLE: begin
        if (rescan) begin
          state_d = SCAN;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // State register; reset restarts a full scan from word 0.
  always_ff @(posedge romclk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      idx_q     <= '0;
      acc_q     <= '0;
      csum_q    <= '0;
      boot_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      csum_q    <= csum_d;
      boot_ok_q <= boot_ok_d;
    end
  end

  assign scan_idx = idx_q;
  assign ready    = (state_q == IDLE);
  assign csum     = csum_q;
  assign boot_ok  = boot_ok_q;

endmodule
`default_nettype wire

// File: rtl/bootrom_gen.sv
`default_nettype none
// ============================================================================
// Module      : bootrom_gen
// Description : Parametrised boot ROM: flop array with read-only image and
//               writable tail, sticky write lock, registered reads and a
//               reset-time checksum scan that holds off CPU accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module bootrom_gen
  import bootrom_gen_pkg::*;
#(
  parameter int            DW       = 16,
  parameter int            AW       = 4,
  parameter int            DEPTH    = 16,
  parameter int            RW_BASE  = 7,
  parameter logic [DW-1:0] EXP_CSUM = DW'(EXP_CSUM_DEFAULT)
) (
  input wire           romclk,
  input wire           rst,
  bootrom_gen_if.slave bus
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          lock_q, lock_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;

  logic          ready;
  logic [AW-1:0] scan_idx;
  logic [DW-1:0] csum;
  logic          boot_ok;
  logic          addr_in_range;
  logic          addr_writable;

  assign addr_in_range = 32'(bus.addr) < 32'(DEPTH);
  assign addr_writable = addr_in_range && (32'(bus.addr) >= 32'(RW_BASE));

  bootrom_gen_scan #(
    .DW       (DW),
    .AW       (AW),
    .DEPTH    (DEPTH),
    .EXP_CSUM (EXP_CSUM)
  ) u_scan (
    .romclk   (romclk),
    .rst      (rst),
    .rescan   (bus.rescan),
    .word     (mem_q[scan_idx]),
    .scan_idx (scan_idx),
    .ready    (ready),
    .csum     (csum),
    .boot_ok  (boot_ok)
  );

  // Access decode; lock sampled on this edge already blocks this edge's write.
  always_comb begin
    mem_d    = mem_q;
    lock_d   = lock_q | bus.lock;
    dout_d   = dout_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    if (ready && bus.cs) begin
      if (!bus.we) begin
        rvalid_d = 1'b1;
        if (addr_in_range) begin
          dout_d = mem_q[bus.addr];
        end else begin
          dout_d = '0;
          err_d  = 1'b1;
        end
      end else if (addr_writable && !lock_d) begin
        mem_d[bus.addr] = bus.din;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Array and access registers; reset reloads the boot image.
  always_ff @(posedge romclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DW'(image_word(i));
      end
      lock_q   <= 1'b0;
      dout_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      lock_q   <= lock_d;
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign bus.ready   = ready;
  assign bus.dout    = dout_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.err     = err_q;
  assign bus.csum    = csum;
  assign bus.boot_ok = boot_ok;

endmodule
`default_nettype wire

// File: tb/tb_bootrom_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_bootrom_gen
// Description : Self-checking bench for bootrom_gen: directed vector table,
//               hand-written scan/lock/reset sequences and random traffic
//               against a behavioural memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bootrom_gen;

  localparam int          DW      = 16;
  localparam int          AW      = 4;
  localparam int          DEPTH   = 16;
  localparam int          RW_BASE = 7;
  localparam logic [15:0] EXP     = 16'h9E0F;

  logic romclk = 1'b0;
  logic rst;

  bootrom_gen_if #(.DW(DW), .AW(AW)) bus ();

  bootrom_gen #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .RW_BASE(RW_BASE), .EXP_CSUM(EXP)
  ) dut (
    .romclk (romclk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 romclk = ~romclk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: array contents, lock flag, cycles since scan start.
  logic [15:0] img [DEPTH] = '{16'hF200, 16'h4000, 16'hF800, 16'h1007,
                               16'hF400, 16'h3008, 16'h4000, 16'h0000,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] m_mem [DEPTH];
  logic        m_lock, m_ready, m_rvalid, m_err, m_boot_ok;
  logic [15:0] m_dout, m_csum;
  int          m_cnt;

  typedef struct {
    logic        cs;
    logic        we;
    logic [3:0]  addr;
    logic [15:0] din;
    logic        exp_rvalid;
    logic        exp_err;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [15:0] mem_sum();
    logic [15:0] s;
    s = 16'h0000;
    foreach (m_mem[i]) s = s + m_mem[i];
    return s;
  endfunction

  task automatic model_reset();
    m_mem     = img;
    m_lock    = 1'b0;
    m_ready   = 1'b0;
    m_cnt     = 0;
    m_rvalid  = 1'b0;
    m_err     = 1'b0;
    m_boot_ok = 1'b0;
    m_dout    = 16'h0000;
    m_csum    = 16'h0000;
  endtask

  // Apply the rules for one rising edge with the currently driven inputs.
  task automatic model_edge();
    logic rv, er;
    int   a;
    rv = 1'b0;
    er = 1'b0;
    a  = int'(bus.addr);
    if (m_ready && bus.cs) begin
      if (!bus.we) begin
        rv = 1'b1;
        if (a < DEPTH) m_dout = m_mem[a];
        else begin
          m_dout = 16'h0000;
          er     = 1'b1;
        end
      end else if (a >= RW_BASE && a < DEPTH && !(m_lock || bus.lock)) begin
        m_mem[a] = bus.din;
      end else begin
        er = 1'b1;
      end
    end
    if (bus.lock) m_lock = 1'b1;
    if (m_ready) begin
      if (bus.rescan) begin
        m_ready = 1'b0;
        m_cnt   = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == DEPTH + 1) begin
        m_ready   = 1'b1;
        m_csum    = mem_sum();
        m_boot_ok = (m_csum == EXP);
      end
    end
    m_rvalid = rv;
    m_err    = er;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ready",   32'(bus.ready),   32'(m_ready));
    chk("rvalid",  32'(bus.rvalid),  32'(m_rvalid));
    chk("err",     32'(bus.err),     32'(m_err));
    chk("dout",    32'(bus.dout),    32'(m_dout));
    chk("csum",    32'(bus.csum),    32'(m_csum));
    chk("boot_ok", 32'(bus.boot_ok), 32'(m_boot_ok));
  endtask

  // One clock: model the edge, then sample 1 time unit after it.
  task automatic cycle();
    @(posedge romclk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic cs, input logic we, input logic [3:0] addr,
                       input logic [15:0] din, input logic lock, input logic rescan);
    bus.cs     = cs;
    bus.we     = we;
    bus.addr   = addr;
    bus.din    = din;
    bus.lock   = lock;
    bus.rescan = rescan;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges, released after one edge.
  task automatic apply_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge romclk);
    #1;
    rst = 1'b0;
  endtask

  // Count cycles until ready rises, bounded.
  task automatic wait_ready(input string name, input int exp_len);
    int n;
    n = 0;
    while (!bus.ready && n < 40) begin
      cycle();
      n++;
    end
    chk(name, 32'(n), 32'(exp_len));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1'b0;
    #1;

    // Power-up scan with no traffic.
    apply_reset();
    wait_ready("scan_len_reset", 17);
    chk("csum_reset", 32'(bus.csum), 32'h9E0F);
    chk("boot_ok_reset", 32'(bus.boot_ok), 32'h1);

    // Directed access vectors from IDLE.
    vecs[0]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 16'hF200};
    vecs[1]  = '{1'b1, 1'b0, 4'd1,  16'h0000, 1'b1, 1'b0, 16'h4000};
    vecs[2]  = '{1'b1, 1'b0, 4'd3,  16'h0000, 1'b1, 1'b0, 16'h1007};
    vecs[3]  = '{1'b1, 1'b1, 4'd7,  16'hA5A5, 1'b0, 1'b0, 16'h1007};
    vecs[4]  = '{1'b1, 1'b0, 4'd7,  16'h0000, 1'b1, 1'b0, 16'hA5A5};
    vecs[5]  = '{1'b1, 1'b1, 4'd2,  16'h1111, 1'b0, 1'b1, 16'hA5A5};
    vecs[6]  = '{1'b1, 1'b0, 4'd2,  16'h0000, 1'b1, 1'b0, 16'hF800};
    vecs[7]  = '{1'b1, 1'b1, 4'd6,  16'h2222, 1'b0, 1'b1, 16'hF800};
    vecs[8]  = '{1'b1, 1'b0, 4'd6,  16'h0000, 1'b1, 1'b0, 16'h4000};
    vecs[9]  = '{1'b1, 1'b1, 4'd15, 16'hBEEF, 1'b0, 1'b0, 16'h4000};
    vecs[10] = '{1'b1, 1'b0, 4'd15, 16'h0000, 1'b1, 1'b0, 16'hBEEF};
    vecs[11] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 16'hBEEF};
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].cs, vecs[i].we, vecs[i].addr, vecs[i].din, 1'b0, 1'b0);
      cycle();
      chk($sformatf("vec%0d_rvalid", i), 32'(bus.rvalid), 32'(vecs[i].exp_rvalid));
      chk($sformatf("vec%0d_err", i),    32'(bus.err),    32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_dout", i),   32'(bus.dout),   32'(vecs[i].exp_dout));
    end

    // Lock: write on the first lock edge and after it are both rejected.
    drive(1'b1, 1'b1, 4'd10, 16'h5555, 1'b1, 1'b0);
    cycle();
    chk("lock_same_edge_err", 32'(bus.err), 32'h1);
    drive(1'b1, 1'b1, 4'd9, 16'h1234, 1'b0, 1'b0);
    cycle();
    chk("locked_write_err", 32'(bus.err), 32'h1);
    drive(1'b1, 1'b0, 4'd9, 16'h0000, 1'b0, 1'b0);
    cycle();
    chk("locked_read9", 32'(bus.dout), 32'h0000);
    idle();
    cycle();

    // Reset clears lock; write to 9 then goes through.
    apply_reset();
    wait_ready("scan_len_after_lock", 17);
    drive(1'b1, 1'b1, 4'd9, 16'h1234, 1'b0, 1'b0);
    cycle();
    chk("unlocked_write_err", 32'(bus.err), 32'h0);
    drive(1'b1, 1'b0, 4'd9, 16'h0000, 1'b0, 1'b0);
    cycle();
    chk("unlocked_read9", 32'(bus.dout), 32'h1234);
    idle();
    cycle();

    // Modified tail word changes the rescan checksum.
    apply_reset();
    wait_ready("scan_len_pre_rescan", 17);
    drive(1'b1, 1'b1, 4'd8, 16'h0001, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
    cycle();
    idle();
    chk("ready_after_rescan", 32'(bus.ready), 32'h0);
    chk("csum_held_in_rescan", 32'(bus.csum), 32'h9E0F);
    wait_ready("scan_len_rescan", 17);
    chk("csum_rescan", 32'(bus.csum), 32'h9E10);
    chk("boot_ok_rescan", 32'(bus.boot_ok), 32'h0);

    // Reset while the scan is at word 5, reads held off during the rescan.
    apply_reset();
    for (int i = 0; i < 5; i++) cycle();
    apply_reset();
    drive(1'b1, 1'b0, 4'd3, 16'h0000, 1'b0, 1'b0);
    wait_ready("scan_len_mid_reset", 17);
    idle();
    chk("csum_mid_reset", 32'(bus.csum), 32'h9E0F);
    chk("boot_ok_mid_reset", 32'(bus.boot_ok), 32'h1);
    chk("no_rvalid_in_scan", 32'(bus.rvalid), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        idle();
        apply_reset();
      end else begin
        drive($urandom_range(0, 9) < 7,
              1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)),
              16'($urandom),
              (i > 2200) && ($urandom_range(0, 99) == 0),
              $urandom_range(0, 59) == 0);
        cycle();
      end
    end
    idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
